regfile_dump_reader: RTL and testbench

//  Sequential reader for the 32x32 register file: on request, walks an address

---
 rtl/regfile_dump_reader_if.sv | 25 ++
 rtl/regfile_dump_reader.sv | 142 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Dump stream from the regfile dump reader to its consumer: one (addr, data)
// word per valid/ready handshake.
interface regfile_dump_reader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range on one regfile read port and streams
// (addr, data) snapshots out over valid/ready; used while the core is halted.
module regfile_dump_reader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     first_addr_i,
    input  logic [ADDR_W-1:0]     last_addr_i,
    input  logic                  abort_i,
    output logic [ADDR_W-1:0]     rf_addr_o,
    input  logic [DATA_W-1:0]     rf_data_i,
    regfile_dump_reader_if.master dump,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_c;

    assign hs_c = valid_q & dump.dump_ready;

    // State and all outputs are registered; next values come from the FSM below.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rf_addr_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rf_addr_q <= rf_addr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state plus the output values that belong to that next state.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rf_addr_d = '0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cur_d  = first_addr_i;
                    last_d = last_addr_i;
                    busy_d = 1'b1;
                    if (first_addr_i <= last_addr_i) begin
                        state_d   = S_READ;
                        rf_addr_d = first_addr_i;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_READ: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_OUT;
                    addr_d    = cur_q;
                    data_d    = rf_data_i;
                    rf_addr_d = cur_q;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            S_OUT: begin
                // A handshake coinciding with abort still counts as delivered.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (hs_c) begin
                    busy_d = 1'b1;
                    if (cur_q == last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        cur_d     = ADDR_W'(cur_q + ADDR_W'(1));
                        rf_addr_d = ADDR_W'(cur_q + ADDR_W'(1));
                    end
                end else begin
                    rf_addr_d = cur_q;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rf_addr_o       = rf_addr_q;
    assign dump.dump_valid = valid_q;
    assign dump.dump_addr  = addr_q;
    assign dump.dump_data  = data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus pushes expected words,
// a negedge monitor pops and compares them on every handshake.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;
    logic [31:0] rf [32];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int word_cnt = 0;
    logic [36:0] exp_q [$];

    regfile_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ifc ();

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .first_addr_i(first),
        .last_addr_i (last),
        .abort_i     (abort),
        .rf_addr_o   (rf_addr),
        .rf_data_i   (rf_data),
        .dump        (ifc),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    assign rf_data = rf[rf_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the head of the queue.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (ifc.dump_valid === 1'b1 && ifc.dump_ready === 1'b1) begin
            word_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL word: unexpected (%0d,0x%08h) with empty queue",
                         ifc.dump_addr, ifc.dump_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({ifc.dump_addr, ifc.dump_data} !== e) begin
                    n_err++;
                    $display("FAIL word: got (%0d,0x%08h) expected (%0d,0x%08h)",
                             ifc.dump_addr, ifc.dump_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        start = 1'b1;
        first = f;
        last  = l;
        cycle();
        start = 1'b0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_word(input logic [4:0] a);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ifc.dump_valid === 1'b1 && ifc.dump_addr === a) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) check("wait_word timeout", 64'(a), 64'hdead);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok) check("wait_idle timeout", 64'(busy), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        bit [7:0] ev;
        bit [7:0] ed;
        bit [7:0] eb;

        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst = 1'b0;
        start = 1'b0;
        first = '0;
        last = '0;
        abort = 1'b0;
        ifc.dump_ready = 1'b0;
        cycle();
        cycle();
        check("reset valid", 64'(ifc.dump_valid), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        check("reset rf_addr", 64'(rf_addr), 64'h0);
        check("reset dump", 64'({ifc.dump_addr, ifc.dump_data}), 64'h0);
        rst = 1'b1;
        cycle();

        // Test 1: three words, two cycles apart, single done pulse.
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        push(5'd1, 32'h11); push(5'd2, 32'h22); push(5'd3, 32'h33);
        ifc.dump_ready = 1'b1;
        d0 = done_cnt;
        ev = 8'b0010_1010;
        ed = 8'b0100_0000;
        eb = 8'b0111_1111;
        start_dump(5'd1, 5'd3);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1 valid[%0d]", k), 64'(ifc.dump_valid), 64'(ev[k]));
            check($sformatf("t1 done[%0d]", k), 64'(done), 64'(ed[k]));
            check($sformatf("t1 busy[%0d]", k), 64'(busy), 64'(eb[k]));
            cycle();
        end
        check("t1 done count", 64'(done_cnt - d0), 64'h1);

        // Test 2: stall on word 2, regfile write during stall must not leak.
        push(5'd1, 32'h11); push(5'd2, 32'h22); push(5'd3, 32'h33);
        start_dump(5'd1, 5'd3);
        wait_word(5'd2);
        ifc.dump_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t2 stall valid", 64'(ifc.dump_valid), 64'h1);
            check("t2 stall addr", 64'(ifc.dump_addr), 64'h2);
            check("t2 stall data", 64'(ifc.dump_data), 64'h22);
            check("t2 stall rf_addr", 64'(rf_addr), 64'h2);
            if (k == 1) rf[2] = 32'hFF;
            cycle();
        end
        ifc.dump_ready = 1'b1;
        wait_idle();
        rf[2] = 32'h22;

        // Test 3: top register only, no wrap to 0.
        rf[31] = 32'h01c00f93;
        push(5'd31, 32'h01c00f93);
        w0 = word_cnt;
        d0 = done_cnt;
        start_dump(5'd31, 5'd31);
        wait_idle();
        repeat (3) cycle();
        check("t3 words", 64'(word_cnt - w0), 64'h1);
        check("t3 done count", 64'(done_cnt - d0), 64'h1);

        // Test 4: empty range goes straight to DONE.
        w0 = word_cnt;
        start_dump(5'd5, 5'd2);
        check("t4 done", 64'(done), 64'h1);
        check("t4 busy", 64'(busy), 64'h1);
        check("t4 valid", 64'(ifc.dump_valid), 64'h0);
        cycle();
        check("t4 done off", 64'(done), 64'h0);
        check("t4 busy off", 64'(busy), 64'h0);
        check("t4 words", 64'(word_cnt - w0), 64'h0);

        // Test 5: abort while word 2 is offered; a later start still works.
        push(5'd0, 32'h0); push(5'd1, 32'h11);
        d0 = done_cnt;
        start_dump(5'd0, 5'd4);
        wait_word(5'd2);
        ifc.dump_ready = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t5 valid after abort", 64'(ifc.dump_valid), 64'h0);
        check("t5 busy after abort", 64'(busy), 64'h0);
        repeat (3) cycle();
        check("t5 no done", 64'(done_cnt - d0), 64'h0);
        ifc.dump_ready = 1'b1;
        push(5'd3, 32'h33);
        start_dump(5'd3, 5'd3);
        wait_idle();

        // Test 6a: start while busy is ignored, range unchanged.
        push(5'd1, 32'h11); push(5'd2, 32'h22); push(5'd3, 32'h33);
        w0 = word_cnt;
        start_dump(5'd1, 5'd3);
        start = 1'b1; first = 5'd5; last = 5'd6;
        repeat (4) cycle();
        start = 1'b0;
        wait_idle();
        repeat (2) cycle();
        check("t6 words", 64'(word_cnt - w0), 64'h3);

        // Test 6b: reset mid-dump clears everything, no done.
        ifc.dump_ready = 1'b0;
        d0 = done_cnt;
        start_dump(5'd1, 5'd3);
        wait_word(5'd1);
        rst = 1'b0;
        cycle();
        check("t6 rst valid", 64'(ifc.dump_valid), 64'h0);
        check("t6 rst busy", 64'(busy), 64'h0);
        check("t6 rst rf_addr", 64'(rf_addr), 64'h0);
        check("t6 rst dump", 64'({ifc.dump_addr, ifc.dump_data}), 64'h0);
        rst = 1'b1;
        ifc.dump_ready = 1'b1;
        repeat (3) cycle();
        check("t6 idle after rst", 64'(busy), 64'h0);
        check("t6 no done", 64'(done_cnt - d0), 64'h0);

        check("queue empty", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
